// File: rtl/mem_wb_pipe_pkg.sv
// Shared CPU types and constants, extended with the MEM->WB beat and queue state.
package mem_wb_pipe_pkg;

  typedef logic        Bit_t;
  typedef logic [4:0]  Reg_addr_t;
  typedef logic [31:0] Word_t;

  localparam Bit_t      ENABLE    = 1'b1;
  localparam Bit_t      DISABLE   = 1'b0;
  localparam Reg_addr_t REG_ZERO  = 5'd0;
  localparam Word_t     ZERO_WORD = 32'd0;

  localparam int WB_NCH_MAX = 4;

  // Widest beat for the default register-file geometry.
  typedef struct packed {
    Bit_t      [WB_NCH_MAX-1:0] write;
    Reg_addr_t [WB_NCH_MAX-1:0] addr;
    Word_t     [WB_NCH_MAX-1:0] data;
  } wb_beat_t;

  // Encodings equal the number of buffered beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wbq_state_t;

  function automatic logic [1:0] state_occupancy(wbq_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/mem_wb_beat_filter.sv
// Per-channel write-enable filter: $zero squashing and same-address de-duplication.
module mem_wb_beat_filter #(
  parameter int NCH         = 1,
  parameter int AW          = 5,
  parameter bit SQUASH_ZERO = 1'b1
) (
  input  logic [NCH-1:0]    write_i,
  input  logic [NCH*AW-1:0] addr_i,
  output logic [NCH-1:0]    write_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [AW-1:0] addr;
      logic          is_zero;
      logic          younger_hit;

      assign addr    = addr_i[gi*AW +: AW];
      assign is_zero = (addr == {AW{1'b0}});

      // A younger (higher-index) channel writing the same register supersedes this one.
      always_comb begin
        younger_hit = 1'b0;
        for (int j = gi + 1; j < NCH; j++) begin
          if (write_i[j] && (addr_i[j*AW +: AW] == addr) && !is_zero) begin
            younger_hit = 1'b1;
          end
        end
      end

      assign write_o[gi] = write_i[gi] && !(SQUASH_ZERO && is_zero) && !younger_hit;
    end
  endgenerate

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB stage register: NCH write channels, 2-entry skid buffer, flush and write filtering.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int NCH         = 1,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter bit SQUASH_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [NCH-1:0]    mem_wreg_write,
  input  logic [NCH*AW-1:0] mem_wreg_addr,
  input  logic [NCH*DW-1:0] mem_wreg_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [NCH-1:0]    wb_wreg_write,
  output logic [NCH*AW-1:0] wb_wreg_addr,
  output logic [NCH*DW-1:0] wb_wreg_data,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [NCH-1:0]    write;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] data;
  } beat_t;

  wbq_state_t state_q, state_d;
  beat_t      head_q, head_d;
  beat_t      skid_q, skid_d;
  logic       mem_ready_q;
  logic [NCH-1:0] filt_write;
  beat_t      in_beat;
  logic       accept;
  logic       drain;

  mem_wb_beat_filter #(
    .NCH         (NCH),
    .AW          (AW),
    .SQUASH_ZERO (SQUASH_ZERO)
  ) u_filter (
    .write_i (mem_wreg_write),
    .addr_i  (mem_wreg_addr),
    .write_o (filt_write)
  );

  assign in_beat = '{write: filt_write, addr: mem_wreg_addr, data: mem_wreg_data};
  assign accept  = mem_valid && mem_ready_q;
  assign drain   = wb_valid && wb_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d      = EMPTY;
      head_d.write = '0;
      skid_d       = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = in_beat;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_d = in_beat;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_beat;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // mem_ready is registered from the next state, so wb_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      mem_ready_q <= ENABLE;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      mem_ready_q <= (state_d != FULL) ? ENABLE : DISABLE;
    end
  end

  assign mem_ready     = mem_ready_q;
  assign wb_valid      = (state_q != EMPTY);
  assign wb_wreg_write = head_q.write & {NCH{wb_valid}};
  assign wb_wreg_addr  = head_q.addr;
  assign wb_wreg_data  = head_q.data;
  assign occupancy     = state_occupancy(state_q);

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM→WB stage register, successor to the fixed single-port MEM/WB latch.
- Carries NCH register-write channels per beat (dual-issue ready).
- Adds valid/ready backpressure through a 2-entry skid buffer, a synchronous flush, $zero write squashing, and intra-beat same-address write de-duplication.
- Sits between the MEM stage and the register-file write port; WB consumes a beat when wb_valid && wb_ready.

Parameters:
NCH, 1, number of write channels per beat (1..4)
AW, 5, register address width
DW, 32, register data width
SQUASH_ZERO, 1, 1 = force write enable low for any channel whose address is REG_ZERO

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush; discards all buffered and incoming beats
mem_valid  in  1  MEM presents a beat
mem_ready  out  1  registered; block can accept a beat this cycle
mem_wreg_write  in  NCH  per-channel write enable
mem_wreg_addr  in  NCH*AW  per-channel destination register, channel i at [i*AW +: AW]
mem_wreg_data  in  NCH*DW  per-channel write data, channel i at [i*DW +: DW]
wb_valid  out  1  head beat valid
wb_ready  in  1  WB consumes head beat
wb_wreg_write  out  NCH  per-channel write enable, forced 0 when !wb_valid
wb_wreg_addr  out  NCH*AW  head-beat addresses
wb_wreg_data  out  NCH*DW  head-beat data
occupancy  out  2  number of buffered beats (0..2)

Behaviour:
- Reset (async, rst=1):
  - state EMPTY, wb_valid=0, mem_ready=1, occupancy=0.
  - wb_wreg_write all 0; wb_wreg_addr all REG_ZERO; wb_wreg_data all ZERO_WORD; skid entry cleared.
- Handshakes:
  - accept = mem_valid && mem_ready.
  - drain = wb_valid && wb_ready.
  - mem_ready is a flop equal to (next state != FULL). No combinational path from wb_ready to mem_ready.
- States (occupancy 0/1/2):
  - EMPTY: accept → ONE, beat loaded into head.
  - ONE:
    - accept && drain → ONE; head replaced by the new beat.
    - accept && !drain → FULL; beat loaded into skid.
    - !accept && drain → EMPTY.
    - otherwise hold.
  - FULL (mem_ready=0):
    - drain → ONE; skid moves to head and the skid entry is cleared.
    - otherwise hold.
  - Whenever mem_ready=0, accept is 0 by definition.
- Latency: a beat accepted in cycle N with the block EMPTY appears with wb_valid=1 in cycle N+1. Throughput is 1 beat/cycle while wb_ready=1.
- Flush:
  - Highest priority over accept and drain.
  - Next state EMPTY, wb_valid=0, mem_ready=1 next cycle.
  - A beat offered in the flush cycle is dropped.
  - Head/skid data need not clear, but wb_wreg_write must read 0.
- Beat filter, applied at capture, so stored beats are already filtered:
  - If SQUASH_ZERO and addr_i==REG_ZERO, write_i=0.
  - If channels i<j both write the same non-zero address, write_i=0. The higher index is younger in program order and wins.
  - Data and address are stored unmodified.
- Stability: while wb_valid && !wb_ready, the head outputs must not change.
- Reset mid-operation: all buffered beats are lost and the outputs return to reset values immediately. mem_ready=1 on the first edge after rst deasserts.
- No X propagation: skid contents are never visible on the outputs.

Decomposition:
- Shared package, extending the existing cpu defines:
  - Bit_t, Reg_addr_t, Word_t, ENABLE/DISABLE, REG_ZERO, ZERO_WORD (existing).
  - New packed struct wb_beat_t: write[NCH], addr[NCH], data[NCH].
  - New enum wbq_state_t: EMPTY, ONE, FULL.
- Sub-module mem_wb_beat_filter: combinational, parametrised by NCH/AW/SQUASH_ZERO; squash and de-dup rules only.
- mem_wb_pipe holds the FSM, head and skid registers, and output gating.

Test Plan:
- Reset then one beat: NCH=1, write=1, addr=5, data=0xDEADBEEF with wb_ready=1 → next cycle wb_valid=1 with write=1, addr=5, data=0xDEADBEEF; the cycle after, wb_valid=0 and occupancy=0.
- Backpressure: wb_ready=0 with beats A, B offered on consecutive cycles → occupancy=2, mem_ready=0 the cycle after B is accepted, head=A held stable. Raise wb_ready → A, then B, in order; mem_ready=1 one cycle after A drains.
- Zero squash: write=1, addr=0, data=0x12345678 → wb_wreg_write=0, addr=0, data=0x12345678 passed through. With SQUASH_ZERO=0 → write=1.
- Dual-issue collision: NCH=2, ch0 {1,8,0x1}, ch1 {1,8,0x2} → wb_wreg_write=2'b10. Next beat ch0 {1,8}, ch1 {1,9} → 2'b11.
- Flush: FULL state plus flush=1 with mem_valid=1 → next cycle wb_valid=0, occupancy=0, mem_ready=1, all wb_wreg_write=0; the flush-cycle beat never appears.
- Async reset mid-stream: assert rst between clock edges while FULL → outputs reach reset values before the next edge. Deassert rst → first beat accepted normally with 1-cycle latency.
